vic_sched: RTL
==============

Name: vic_sched

Overview:
- Interrupt scheduler for the VICtor controller; sits between the per-line edge/level detection stage and the CPU interrupt interface.
- Latches 31 pending requests, applies the mask and global enable, and picks one winner by fixed or rotating priority.
- Presents the winner to the CPU with a request/acknowledge/end-of-interrupt handshake.
- Re-arms level-sensitive sources that are still active at end-of-interrupt.

Parameters:
- NIRQ, 31, number of interrupt lines; o_irq_addr width is 5.
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins); 1 = rotating (search starts at last served index + 1, wraps 30 to 0).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_en  in  1  global interrupt enable.
- i_set  in  31  one-cycle pulses from the detection stage; set the pending bit.
- i_lvl  in  31  1 = source is level-configured and its level is currently active.
- i_mask  in  31  1 = line enabled.
- i_ack  in  1  CPU accepted the request (pulse).
- i_eoi  in  1  CPU finished the ISR (pulse).
- i_err_clr  in  1  clears o_err.
- o_IRQ  out  1  interrupt request to the CPU; held until acknowledged.
- o_irq_addr  out  5  index of the line being requested or serviced.
- o_busy  out  1  high in ACTIVE.
- o_pending  out  31  raw pending register.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (i_rst=0, asynchronous): o_IRQ=0, o_irq_addr=0, o_busy=0, o_pending=0, o_err=0, state=IDLE, last-served pointer=30 (so the first rotating search starts at 0).
- Pending register: pend <= (pend & ~clr) | i_set.
  - clr is one-hot at o_irq_addr only on an i_eoi cycle in ACTIVE, and only when i_lvl[o_irq_addr]=0.
  - When set and clear hit the same bit in the same cycle, set wins.
- Eligible vector: pend & i_mask, qualified by i_en.
- FSM states: IDLE, REQ, ACTIVE.
- IDLE:
  - When eligible is non-zero, latch the winner into o_irq_addr and go to REQ.
  - o_IRQ=1 from the first REQ cycle.
  - Latency: i_set pulse at edge N, pending visible after edge N, o_IRQ high after edge N+1.
- REQ:
  - o_IRQ held high; o_irq_addr frozen, even if the mask or pending bits change.
  - i_ack=1: o_IRQ=0, o_busy=1, go to ACTIVE.
  - i_en=0 (without ack): o_IRQ=0, go to IDLE; the pending bit is retained.
  - i_ack and i_en falling in the same cycle: the ack wins.
- ACTIVE:
  - No nesting; new requests only accumulate in pend.
  - i_eoi=1: clear the pending bit (unless its i_lvl bit is set), o_busy=0, update last-served pointer to o_irq_addr, go to IDLE.
  - The next arbitration happens in the following IDLE cycle, so there is a 1-cycle minimum gap between o_IRQ pulses.
  - i_en falling during ACTIVE has no effect until EOI.
- Level re-arm: if i_lvl[k]=1 at EOI, bit k stays pending and is re-requested, subject to priority.
- Protocol errors: o_err is set by i_ack outside REQ, by i_eoi outside ACTIVE, or by i_ack and i_eoi high together. i_err_clr clears o_err; a new error in the same cycle wins.
- Rotating mode: the search order is (ptr+1) mod 31 up to ptr; the winner is the first eligible line in that order.
- All outputs are registered.

Test Plan:
- Reset: hold i_rst=0 and toggle every input -> all outputs 0. Release reset, then pulse i_set[5] with i_mask=all-ones and i_en=1 -> pend[5]=1 after 1 edge, o_IRQ=1 with o_irq_addr=5 after 2 edges. Then ack -> o_busy=1; then eoi -> pend=0 and o_busy=0.
- Fixed priority: pulse i_set bits 3, 9 and 20 together -> served in order 3, 9, 20 across three ack/eoi rounds. Set bit 1 during the service of 3 -> order becomes 3, 1, 9, 20.
- Rotating priority (PRIO_MODE=1): keep bits 2 and 7 continuously re-set -> served in order 2, 7, 2, 7. Then with ptr=30 and bits 0 and 30 pending -> 0 is served first.
- Mask and enable: pend[4]=1 with i_mask[4]=0 -> no o_IRQ; unmask -> o_IRQ after 1 edge. Drop i_en during REQ -> o_IRQ=0 and pend[4] stays 1.
- Level re-arm: i_lvl[6]=1 at EOI -> pend[6] stays 1 and o_IRQ is reasserted with addr 6. With i_lvl[6]=0 -> the bit clears. i_set[6] in the same cycle as EOI -> the bit stays set.
- Errors and async reset: i_eoi in IDLE -> o_err=1; i_err_clr -> 0. Assert i_rst low mid-ACTIVE -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/vic_sched.sv
// VICtor interrupt scheduler: latches pending lines, arbitrates (fixed or rotating)
// and drives the CPU request/ack/EOI handshake with level re-arm on EOI.
module vic_sched #(
    parameter int NIRQ      = 31,
    parameter int PRIO_MODE = 0,
    localparam int AW       = $clog2(NIRQ)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [NIRQ-1:0] i_set,
    input  logic [NIRQ-1:0] i_lvl,
    input  logic [NIRQ-1:0] i_mask,
    input  logic            i_ack,
    input  logic            i_eoi,
    input  logic            i_err_clr,
    output logic            o_IRQ,
    output logic [AW-1:0]   o_irq_addr,
    output logic            o_busy,
    output logic [NIRQ-1:0] o_pending,
    output logic            o_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACTIVE} state_t;

    state_t          r_state, w_nstate;
    logic [NIRQ-1:0] r_pend;
    logic [AW-1:0]   r_addr, r_ptr;
    logic            r_irq, r_busy, r_err;

    logic [NIRQ-1:0] w_elig, w_clr;
    logic [AW-1:0]   w_win, w_addr_nx, w_ptr_nx;
    logic            w_found, w_irq_nx, w_busy_nx, w_err_new;
    int              w_idx;

    assign w_elig = i_en ? (r_pend & i_mask) : '0;

    // Rotating search walks ptr+1 .. ptr with wrap; fixed takes the lowest index.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        if (PRIO_MODE == 0) begin
            for (int i = NIRQ - 1; i >= 0; i--)
                if (w_elig[i]) w_win = AW'(i);
        end else begin
            for (int i = 0; i < NIRQ; i++) begin
                w_idx = int'(r_ptr) + 1 + i;
                if (w_idx >= NIRQ) w_idx = w_idx - NIRQ;
                if (!w_found && w_elig[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = AW'(w_idx);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            S_IDLE:   if (|w_elig) w_nstate = S_REQ;
            S_REQ:    if (i_ack) w_nstate = S_ACTIVE;
                      else if (!i_en) w_nstate = S_IDLE;
            S_ACTIVE: if (i_eoi) w_nstate = S_IDLE;
            default:  w_nstate = S_IDLE;
        endcase
    end

    always_comb begin
        w_irq_nx  = (w_nstate == S_REQ);
        w_busy_nx = (w_nstate == S_ACTIVE);
        w_addr_nx = r_addr;
        w_ptr_nx  = r_ptr;
        w_clr     = '0;
        if (r_state == S_IDLE && |w_elig) w_addr_nx = w_win;
        if (r_state == S_ACTIVE && i_eoi) begin
            w_ptr_nx = r_addr;
            if (!i_lvl[r_addr]) w_clr[r_addr] = 1'b1;
        end
        w_err_new = (i_ack && r_state != S_REQ) || (i_eoi && r_state != S_ACTIVE) || (i_ack && i_eoi);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pend <= '0;
            r_addr <= '0;
            r_ptr  <= AW'(NIRQ - 1);
            r_irq  <= 1'b0;
            r_busy <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | i_set;
            r_addr <= w_addr_nx;
            r_ptr  <= w_ptr_nx;
            r_irq  <= w_irq_nx;
            r_busy <= w_busy_nx;
            if (w_err_new)      r_err <= 1'b1;
            else if (i_err_clr) r_err <= 1'b0;
        end
    end

    assign o_IRQ      = r_irq;
    assign o_irq_addr = r_addr;
    assign o_busy     = r_busy;
    assign o_pending  = r_pend;
    assign o_err      = r_err;

endmodule
